// File: rtl/quad_word_serializer_if.sv
// Handshake bundle for quad_word_serializer: 4x16-bit group in, 16-bit word stream out.
// slave = serializer side, master = upstream/downstream environment side.
interface quad_word_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] in_c;
  logic [15:0] in_d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [1:0]  out_sel;
  logic        out_last;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, out_ready,
    output in_ready, out_valid, out, out_sel, out_last
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, out_ready,
    input  in_ready, out_valid, out, out_sel, out_last
  );
endinterface

// File: rtl/quad_word_serializer.sv
// Serializes one 4x16-bit group into four 16-bit beats (a,b,c,d); first beat the cycle after accept, stalls on out_ready low.
// Optional QWS_BACK_TO_BACK_EN: accept the next group during the last beat, removing the idle bubble.
module quad_word_serializer (
  input  logic                   clk,
  input  logic                   reset,
  quad_word_serializer_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      r_state;
  logic [15:0] r_hold_a;
  logic [15:0] r_hold_b;
  logic [15:0] r_hold_c;
  logic [15:0] r_hold_d;
  logic [1:0]  r_sel;
  logic        r_out_valid;

  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_at_last;
  logic [15:0] w_out;

  assign w_at_last = (r_state == SEND) && (r_sel == 2'b11);

`ifdef QWS_BACK_TO_BACK_EN
  assign w_in_ready = !reset && ((r_state == IDLE) || (w_at_last && bus.out_ready));
`else
  assign w_in_ready = !reset && (r_state == IDLE);
`endif

  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  // 4-way word mux over the held operands; depends on registered state only
  always_comb begin
    w_out = r_hold_a;
    case (r_sel)
      2'b00: w_out = r_hold_a;
      2'b01: w_out = r_hold_b;
      2'b10: w_out = r_hold_c;
      2'b11: w_out = r_hold_d;
      default: w_out = r_hold_a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold_a    <= 16'h0000;
      r_hold_b    <= 16'h0000;
      r_hold_c    <= 16'h0000;
      r_hold_d    <= 16'h0000;
      r_sel       <= 2'b00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_hold_a    <= bus.in_a;
            r_hold_b    <= bus.in_b;
            r_hold_c    <= bus.in_c;
            r_hold_d    <= bus.in_d;
            r_sel       <= 2'b00;
            r_out_valid <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (w_out_fire) begin
            if (r_sel == 2'b11) begin
              r_sel <= 2'b00;
              // w_in_fire can only be set here when back-to-back reload is enabled
              if (w_in_fire) begin
                r_hold_a <= bus.in_a;
                r_hold_b <= bus.in_b;
                r_hold_c <= bus.in_c;
                r_hold_d <= bus.in_d;
              end else begin
                r_out_valid <= 1'b0;
                r_state     <= IDLE;
              end
            end else begin
              r_sel <= r_sel + 2'b01;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sel       <= 2'b00;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = w_out;
  assign bus.out_sel   = r_sel;
  assign bus.out_last  = r_out_valid && (r_sel == 2'b11);

endmodule

// File: tb/tb_quad_word_serializer.sv
// Directed bench for quad_word_serializer: vector table plus back-to-back and mid-group reset sequences.
module tb_quad_word_serializer;

`ifdef QWS_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  quad_word_serializer_if bus ();

  quad_word_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] a, b, c, d;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_out;
    logic [1:0]  e_sel;
    logic        e_last;
    logic        e_ir;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [15:0] a, b, c, d,
                              input logic ordy, input logic e_ov, input logic [15:0] e_out,
                              input logic [1:0] e_sel, input logic e_last, input logic e_ir);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.c = c; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_out = e_out; v.e_sel = e_sel; v.e_last = e_last; v.e_ir = e_ir;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] a, b, c, d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_c      = c;
    bus.in_d      = d;
    bus.out_ready = ordy;
  endtask

  localparam logic [15:0] A0 = 16'h1234, A1 = 16'h9876, A2 = 16'hAAAA, A3 = 16'h5555;
  localparam logic [15:0] Z  = 16'h0000;

  logic [15:0] got_words[$];
  logic [15:0] exp_words[8];
  int          first_v, last_v, phase, idx;
  bit          found;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, Z, Z, Z, Z, 1'b1);

    // reset values with no clock edge yet
    #3;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_sel",   32'(bus.out_sel),   32'd0);
    chk("rst out",       32'(bus.out),       32'h0);
    chk("rst out_last",  32'(bus.out_last),  32'd0);
    chk("rst in_ready",  32'(bus.in_ready),  32'd0);
    #5 reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // basic group
    add(1, A0, A1, A2, A3, 1, 0, Z,  2'd0, 0, 1);
    add(0, Z,  Z,  Z,  Z,  1, 1, A0, 2'd0, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, A1, 2'd1, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, A2, 2'd2, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, A3, 2'd3, 1, B2B);
    // backpressure on word b for three cycles
    add(1, A0, A1, A2, A3, 1, 0, A0, 2'd0, 0, 1);
    add(0, Z,  Z,  Z,  Z,  1, 1, A0, 2'd0, 0, 0);
    add(0, Z,  Z,  Z,  Z,  0, 1, A1, 2'd1, 0, 0);
    add(0, Z,  Z,  Z,  Z,  0, 1, A1, 2'd1, 0, 0);
    add(0, Z,  Z,  Z,  Z,  0, 1, A1, 2'd1, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, A1, 2'd1, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, A2, 2'd2, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, A3, 2'd3, 1, B2B);
    // second group presented while busy
    add(1, A0, A1, A2, A3, 1, 0, A0, 2'd0, 0, 1);
    add(1, Z,  Z,  Z,  Z,  1, 1, A0, 2'd0, 0, 0);
    add(1, Z,  Z,  Z,  Z,  1, 1, A1, 2'd1, 0, 0);
    add(1, Z,  Z,  Z,  Z,  1, 1, A2, 2'd2, 0, 0);
    add(1, Z,  Z,  Z,  Z,  1, 1, A3, 2'd3, 1, B2B);
`ifndef QWS_BACK_TO_BACK_EN
    add(1, Z,  Z,  Z,  Z,  1, 0, A0, 2'd0, 0, 1);
`endif
    add(0, Z,  Z,  Z,  Z,  1, 1, Z,  2'd0, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, Z,  2'd1, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, Z,  2'd2, 0, 0);
    add(0, Z,  Z,  Z,  Z,  1, 1, Z,  2'd3, 1, B2B);
    add(0, Z,  Z,  Z,  Z,  1, 0, Z,  2'd0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("row%0d out", i),       32'(bus.out),       32'(vecs[i].e_out));
      chk($sformatf("row%0d out_sel", i),   32'(bus.out_sel),   32'(vecs[i].e_sel));
      chk($sformatf("row%0d out_last", i),  32'(bus.out_last),  32'(vecs[i].e_last));
      chk($sformatf("row%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_ir));
      @(posedge clk); #1;
    end

    // two groups offered back to back with in_valid held high
    exp_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                  16'h5555, 16'h6666, 16'h7777, 16'h8888};
    phase   = 0;
    first_v = -1;
    last_v  = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (phase == 0)      drive(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1);
      else if (phase == 1) drive(1, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1);
      else                 drive(0, Z, Z, Z, Z, 1);
      @(negedge clk);
      if (bus.out_valid) begin
        got_words.push_back(bus.out);
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (bus.in_valid && bus.in_ready) phase++;
      @(posedge clk); #1;
    end
    chk("b2b beat count", 32'(got_words.size()), 32'd8);
    if (got_words.size() == 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("b2b word%0d", k), 32'(got_words[k]), 32'(exp_words[k]));
      chk("b2b idle gap", 32'((last_v - first_v + 1) - 8), B2B ? 32'd0 : 32'd1);
    end

    // reset asserted while word c is on the bus
    drive(1, A0, A1, A2, A3, 1);
    @(posedge clk); #1;
    drive(0, Z, Z, Z, Z, 1);
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_sel == 2'd2) found = 1'b1;
    end
    if (!found) begin
      errors++;
      $display("FAIL midrst wait actual=timeout required=out_sel 2");
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst out_sel",   32'(bus.out_sel),   32'd0);
    chk("midrst out",       32'(bus.out),       32'h0);
    chk("midrst in_ready",  32'(bus.in_ready),  32'd0);
    #4 reset = 1'b0;
    @(negedge clk);
    chk("midrst idle valid",    32'(bus.out_valid), 32'd0);
    chk("midrst idle in_ready", 32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    drive(1, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0123, 1);
    @(posedge clk); #1;
    drive(0, Z, Z, Z, Z, 1);
    idx = 0;
    @(negedge clk);
    chk("after rst first out",  32'(bus.out),       32'hBEEF);
    chk("after rst first sel",  32'(bus.out_sel),   32'd0);
    chk("after rst first vld",  32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("after rst second out", 32'(bus.out),       32'hCAFE);
    chk("after rst second sel", 32'(bus.out_sel),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_word_serializer.md
# quad_word_serializer

Accepts a group of four 16-bit words (a, b, c, d) in one handshake and emits them one word per beat, in order a, b, c, d, on a 16-bit valid/ready output stream. It sits directly upstream of the 4-way 16-bit multiplexer stage: it holds the four operands in registers and generates the 2-bit select that steps through them. Internally its output word is exactly the 4-way mux function of the held words and the current select. Used wherever a wide parallel result must be drained over a single 16-bit bus.

## Interface
Parameters: none (word width fixed at 16, group size fixed at 4).

- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  upstream has a group on in_a..in_d
- in_ready  output  1  block will accept a group this cycle
- in_a  input  16  word 0 of group
- in_b  input  16  word 1
- in_c  input  16  word 2
- in_d  input  16  word 3
- out_valid  output  1  out holds a valid word
- out_ready  input  1  downstream accepts out this cycle
- out  output  16  current word = held word selected by out_sel (00→a, 01→b, 10→c, 11→d)
- out_sel  output  2  index of the word on out
- out_last  output  1  high when out_valid and out_sel == 11

## Operation
- State machine, two states: IDLE, SEND.
- IDLE: in_ready = 1 (forced 0 while reset is asserted). On in_valid && in_ready: capture in_a..in_d into holding registers, set out_sel = 00, go to SEND.
- SEND: out_valid = 1. A beat transfers when out_valid && out_ready; out_sel increments by 1.
- Transfer with out_sel == 11: go to IDLE, out_sel returns to 00. Alternatively, reload per Configuration.
- out_ready low in SEND: out, out_sel and the holding registers hold stable. No word is skipped or repeated.
- in_valid in SEND (feature off): ignored and not captured. Upstream must hold the group until in_ready.
- Holding registers change only on an accepted input handshake.
- out is driven from the holding registers in every state. In IDLE it shows the last group's word at out_sel = 00, with out_valid = 0.
- Reset values: state IDLE, out_valid 0, out_sel 00, out_last 0, holding registers 0x0000, out 0x0000. in_ready is 0 during reset and 1 from the first cycle after deassertion.
- Reset asserted mid-group: the group is discarded immediately and no further beats are emitted.

## Timing
- Input accept at edge N → out_valid = 1 with out = a, out_sel = 00 after edge N (visible in cycle N+1).
- Each word lasts ≥1 cycle, and exactly 1 cycle when out_ready is held high.
- Feature off: a group occupies 5 cycles minimum (1 accept + 4 beats). in_ready rises the cycle after the last beat.
- Feature on: a group occupies 4 cycles back-to-back with no bubble.
- out, out_sel and out_last are registered-state-derived only, with no combinational path from out_ready. in_ready depends combinationally on out_ready only when the feature is enabled.

## Configuration
- Macro QWS_BACK_TO_BACK_EN.
- Defined: in SEND with out_sel == 11, in_ready = out_ready. If the final beat transfers and in_valid is high in the same cycle, the new group is captured at that edge and the block stays in SEND with out_sel = 00. The next cycle shows the new word a. If in_valid is low, the block goes to IDLE.
- Undefined: in_ready = 1 only in IDLE, so every group is separated by at least one idle cycle with out_valid = 0.

## Test plan
- Reset: assert reset mid-cycle with no clock → out_valid 0, out_sel 00, out 0x0000, in_ready 0. Deassert → in_ready 1 next cycle.
- Basic group: in_a..d = 0x1234, 0x9876, 0xAAAA, 0x5555, in_valid for 1 cycle, out_ready held 1 → outputs 0x1234/00, 0x9876/01, 0xAAAA/10, 0x5555/11 on 4 consecutive cycles. out_last only on the 4th. Then out_valid 0 and in_ready 1.
- Backpressure: same group, out_ready low for 3 cycles while out = 0x9876 → out and out_sel hold at 0x9876/01. The sequence resumes with no loss or duplication.
- Input ignored while busy (feature off): present a second group 0x0000 ×4 during SEND → the first group drains unchanged and the second is accepted only after in_ready returns.
- Back-to-back (QWS_BACK_TO_BACK_EN): two groups with in_valid held high and out_ready 1 → 8 consecutive valid beats, 1 per cycle, with no out_valid gap. Feature off → exactly one 0 cycle of out_valid between the groups.
- Reset mid-group: assert reset while out_sel = 10 → out_valid 0 immediately. After release the next accepted group starts at out_sel 00.
